disp_frame_ctrl: RTL and testbench

- Frame-buffer sequencer between the drawing side and the XGA display block.
- Owns DISP_ON power-up/down, services the display's sticky VBLANK flag via CLR_VBLANK, and counts frames and FIFO errors.
- Manages double or triple buffering in VRAM: hands the drawer a back-buffer address (DRAW_ADDR) and swaps DISP_ADDR only inside vertical blanking, so the display never reads a half-written frame.

---
 rtl/disp_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_disp_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_frame_ctrl.sv
// Frame-buffer sequencer: display power sequencing, VBLANK servicing and
// double/triple-buffer flips between the drawing side and the XGA display.
//
// state    | meaning
// IDLE     | display off; waiting for ENABLE
// RUN      | display on; service the next VBLANK
// WAIT_CLR | VBLANK serviced; wait until it reads back 0
// STOP     | disable requested; power down after the next VBLANK service
module disp_frame_ctrl #(
    parameter int unsigned                 ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]       BASE_ADDR   = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned                 FRAME_BYTES = 3145728,
    parameter int unsigned                 NUM_BUF     = 2,
    parameter int unsigned                 CNT_WIDTH   = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ENABLE,
    input  logic                  VBLANK,
    output logic                  CLR_VBLANK,
    output logic                  DISP_ON,
    output logic [ADDR_WIDTH-1:0] DISP_ADDR,
    output logic [ADDR_WIDTH-1:0] DRAW_ADDR,
    input  logic                  FLIP_REQ,
    output logic                  FLIP_READY,
    output logic                  FLIP_ACK,
    input  logic                  FIFO_UNDERFLOW,
    input  logic                  FIFO_OVERFLOW,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT,
    output logic [CNT_WIDTH-1:0]  ERR_CNT
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_WAIT_CLR = 2'd2;
    localparam logic [1:0] S_STOP     = 2'd3;

    localparam bit TRIPLE = (NUM_BUF == 3);

    if (NUM_BUF != 2 && NUM_BUF != 3) begin : g_bad_num_buf
        $error("disp_frame_ctrl: NUM_BUF must be 2 or 3");
    end

    function automatic logic [ADDR_WIDTH-1:0] buf_addr(input logic [1:0] idx);
        return BASE_ADDR + ADDR_WIDTH'(FRAME_BYTES) * ADDR_WIDTH'(idx);
    endfunction

    logic [1:0]            state, state_nxt;
    logic                  svc, take, accept, flip_ready;
    logic [1:0]            disp_idx, draw_idx, pend_idx;
    logic [1:0]            disp_nxt, draw_nxt, pend_nxt;
    logic                  pend_vld, pend_vld_nxt;
    logic                  clr_vblank, flip_ack, disp_on;
    logic [ADDR_WIDTH-1:0] disp_addr, draw_addr;
    logic [CNT_WIDTH-1:0]  frame_cnt, err_cnt;
    logic                  err_lvl, err_q;

    always_comb begin
        state_nxt = state;
        svc       = 1'b0;
        case (state)
            S_IDLE: begin
                if (ENABLE) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (VBLANK) begin
                    svc       = 1'b1;
                    state_nxt = S_WAIT_CLR;
                end else if (!ENABLE) begin
                    state_nxt = S_STOP;
                end
            end
            S_WAIT_CLR: begin
                if (!VBLANK) state_nxt = S_RUN;
            end
            S_STOP: begin
                if (ENABLE) begin
                    state_nxt = S_RUN;
                end else if (VBLANK) begin
                    svc       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A double-buffered drawer must wait for the flip to land; triple buffering keeps a spare
    assign flip_ready = !clr_vblank && (TRIPLE || !pend_vld);
    assign accept     = FLIP_REQ && flip_ready;
    assign take       = svc && pend_vld;

    always_comb begin
        disp_nxt     = take ? pend_idx : disp_idx;
        pend_nxt     = accept ? draw_idx : pend_idx;
        pend_vld_nxt = accept || (pend_vld && !svc);
        if (TRIPLE) begin
            // indices are 0..2, so the free buffer is whatever the other two do not sum to
            draw_nxt = accept ? (2'd3 - disp_nxt - draw_idx) : draw_idx;
        end else begin
            draw_nxt = take ? disp_idx : draw_idx;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= S_IDLE;
            disp_on    <= 1'b0;
            clr_vblank <= 1'b0;
            flip_ack   <= 1'b0;
            frame_cnt  <= '0;
            disp_idx   <= 2'd0;
            draw_idx   <= 2'd1;
            pend_idx   <= 2'd0;
            pend_vld   <= 1'b0;
            disp_addr  <= buf_addr(2'd0);
            draw_addr  <= buf_addr(2'd1);
        end else begin
            state      <= state_nxt;
            disp_on    <= (state_nxt != S_IDLE);
            clr_vblank <= svc;
            flip_ack   <= take;
            if (svc) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            disp_idx   <= disp_nxt;
            draw_idx   <= draw_nxt;
            pend_idx   <= pend_nxt;
            pend_vld   <= pend_vld_nxt;
            disp_addr  <= buf_addr(disp_nxt);
            draw_addr  <= buf_addr(draw_nxt);
        end
    end

    assign err_lvl = FIFO_UNDERFLOW | FIFO_OVERFLOW;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_q <= err_lvl;
            if (err_lvl && !err_q && err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
        end
    end

    assign CLR_VBLANK = clr_vblank;
    assign DISP_ON    = disp_on;
    assign DISP_ADDR  = disp_addr;
    assign DRAW_ADDR  = draw_addr;
    assign FLIP_READY = flip_ready;
    assign FLIP_ACK   = flip_ack;
    assign FRAME_CNT  = frame_cnt;
    assign ERR_CNT    = err_cnt;

endmodule

// File: tb/tb_disp_frame_ctrl.sv
// Bench for disp_frame_ctrl: a double- and a triple-buffered instance share one
// stimulus stream and are checked every cycle against a buffer-rotation model.
module tb_disp_frame_ctrl;

    localparam longint unsigned BASE = 64'h1000_0000;
    localparam longint unsigned FB   = 3145728;

    logic ACLK = 1'b0;
    logic ARESET, ENABLE, VBLANK, FLIP_REQ, FIFO_UNDERFLOW, FIFO_OVERFLOW;

    logic        clr2, on2, rdy2, ack2, clr3, on3, rdy3, ack3;
    logic [31:0] da2, wa2, da3, wa3;
    logic [15:0] fc2, ec2, fc3, ec3;

    int n_checks = 0;
    int n_pass   = 0;
    int clr_total = 0;
    int ack3_total = 0;

    always #5 ACLK = ~ACLK;

    disp_frame_ctrl #(.NUM_BUF(2)) u2 (
        .ACLK(ACLK), .ARESET(ARESET), .ENABLE(ENABLE), .VBLANK(VBLANK),
        .CLR_VBLANK(clr2), .DISP_ON(on2), .DISP_ADDR(da2), .DRAW_ADDR(wa2),
        .FLIP_REQ(FLIP_REQ), .FLIP_READY(rdy2), .FLIP_ACK(ack2),
        .FIFO_UNDERFLOW(FIFO_UNDERFLOW), .FIFO_OVERFLOW(FIFO_OVERFLOW),
        .FRAME_CNT(fc2), .ERR_CNT(ec2));

    disp_frame_ctrl #(.NUM_BUF(3)) u3 (
        .ACLK(ACLK), .ARESET(ARESET), .ENABLE(ENABLE), .VBLANK(VBLANK),
        .CLR_VBLANK(clr3), .DISP_ON(on3), .DISP_ADDR(da3), .DRAW_ADDR(wa3),
        .FLIP_REQ(FLIP_REQ), .FLIP_READY(rdy3), .FLIP_ACK(ack3),
        .FIFO_UNDERFLOW(FIFO_UNDERFLOW), .FIFO_OVERFLOW(FIFO_OVERFLOW),
        .FRAME_CNT(fc3), .ERR_CNT(ec3));

    // model: index 0 is the double-buffered instance, index 1 the triple-buffered one
    bit m_on = 0, m_wait = 0, m_stop = 0, m_clr = 0, m_eprev = 0;
    int m_frame = 0;
    int m_disp[2] = '{0, 0};
    int m_draw[2] = '{1, 1};
    int m_pend[2] = '{-1, -1};
    bit m_ack[2]  = '{0, 0};
    int m_err[2]  = '{0, 0};

    function automatic logic [31:0] addr_of(input int k);
        return 32'(BASE + longint'(k) * FB);
    endfunction

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_on = 0; m_wait = 0; m_stop = 0; m_clr = 0; m_eprev = 0; m_frame = 0;
            for (int i = 0; i < 2; i++) begin
                m_disp[i] = 0; m_draw[i] = 1; m_pend[i] = -1; m_ack[i] = 0; m_err[i] = 0;
            end
        end else begin
            bit svc, rdy, lvl;
            int old_draw;
            svc = 0;
            lvl = FIFO_UNDERFLOW | FIFO_OVERFLOW;
            if (!m_on) begin
                if (ENABLE) m_on = 1;
            end else if (m_wait) begin
                if (!VBLANK) m_wait = 0;
            end else if (m_stop) begin
                if (ENABLE) m_stop = 0;
                else if (VBLANK) begin svc = 1; m_on = 0; m_stop = 0; end
            end else if (VBLANK) begin
                svc = 1; m_wait = 1;
            end else if (!ENABLE) begin
                m_stop = 1;
            end
            for (int i = 0; i < 2; i++) begin
                rdy = !m_clr && (i == 1 || m_pend[i] < 0);
                old_draw = m_draw[i];
                m_ack[i] = svc && (m_pend[i] >= 0);
                if (m_ack[i]) begin
                    if (i == 0) m_draw[i] = m_disp[i];
                    m_disp[i] = m_pend[i];
                    m_pend[i] = -1;
                end
                if (FLIP_REQ && rdy) begin
                    m_pend[i] = old_draw;
                    if (i == 1)
                        for (int k = 0; k < 3; k++)
                            if (k != m_disp[i] && k != old_draw) m_draw[i] = k;
                end
                if (lvl && !m_eprev && m_err[i] != 65535) m_err[i] = m_err[i] + 1;
            end
            m_eprev = lvl;
            m_clr = svc;
            if (svc) m_frame = (m_frame + 1) & 16'hFFFF;
        end
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    endtask

    task automatic chk_dut(input int i, input string tag, input logic clr, input logic on,
                           input logic rdy, input logic ack, input logic [31:0] da,
                           input logic [31:0] wa, input logic [15:0] fc, input logic [15:0] ec);
        chk({tag, ".clr_vblank"}, clr, m_clr);
        chk({tag, ".disp_on"},    on,  m_on);
        chk({tag, ".flip_ready"}, rdy, !m_clr && (i == 1 || m_pend[i] < 0));
        chk({tag, ".flip_ack"},   ack, m_ack[i]);
        chk({tag, ".disp_addr"},  da,  addr_of(m_disp[i]));
        chk({tag, ".draw_addr"},  wa,  addr_of(m_draw[i]));
        chk({tag, ".frame_cnt"},  fc,  m_frame);
        chk({tag, ".err_cnt"},    ec,  m_err[i]);
    endtask

    always @(negedge ACLK) begin
        chk_dut(0, "u2", clr2, on2, rdy2, ack2, da2, wa2, fc2, ec2);
        chk_dut(1, "u3", clr3, on3, rdy3, ack3, da3, wa3, fc3, ec3);
        if (clr2) clr_total++;
        if (ack3) ack3_total++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    initial begin
        int clr_before, ack_before;
        ARESET = 1; ENABLE = 0; VBLANK = 0; FLIP_REQ = 0;
        FIFO_UNDERFLOW = 0; FIFO_OVERFLOW = 0;
        step(2);
        chk("rst.disp_on", on2, 0);
        chk("rst.disp_addr", da2, 32'h1000_0000);
        chk("rst.draw_addr", wa2, 32'h1030_0000);
        chk("rst.frame_cnt", fc2, 0);
        chk("rst.clr_ack", {clr2, ack2}, 0);
        ARESET = 0;
        step(1);

        ENABLE = 1;
        chk("pre_enable.disp_on", on2, 0);
        step(1);
        chk("enable.disp_on", on2, 1);
        step(2);

        // first request accepted by both; the second only by the triple-buffered one
        FLIP_REQ = 1;
        step(1);
        chk("acc2.flip_ready", rdy2, 0);
        chk("acc2.draw_addr", wa2, 32'h1030_0000);
        chk("acc3.draw_addr", wa3, 32'h1060_0000);
        chk("acc3.flip_ready", rdy3, 1);
        step(1);
        FLIP_REQ = 0;
        chk("acc3b.draw_addr", wa3, 32'h1030_0000);
        step(2);

        clr_before = clr_total;
        ack_before = ack3_total;
        VBLANK = 1;
        step(1);
        chk("svc2.clr_vblank", clr2, 1);
        chk("svc2.disp_addr", da2, 32'h1030_0000);
        chk("svc2.flip_ack", ack2, 1);
        chk("svc2.draw_addr", wa2, 32'h1000_0000);
        chk("svc2.flip_ready", rdy2, 0);
        chk("svc2.frame_cnt", fc2, 1);
        chk("svc3.disp_addr", da3, 32'h1060_0000);
        step(10);
        VBLANK = 0;
        step(2);
        chk("hold.clr_pulses", clr_total - clr_before, 1);
        chk("hold.ack3_pulses", ack3_total - ack_before, 1);
        chk("hold.frame_cnt", fc2, 1);

        VBLANK = 1; step(1); VBLANK = 0; step(3);
        chk("frame2.frame_cnt", fc2, 2);
        chk("frame2.disp_addr", da2, 32'h1030_0000);

        ENABLE = 0;
        step(5);
        chk("stopping.disp_on", on2, 1);
        VBLANK = 1;
        step(1);
        chk("stop.disp_on", on2, 0);
        chk("stop.clr_vblank", clr2, 1);
        chk("stop.frame_cnt", fc2, 3);
        step(3);
        VBLANK = 0;
        step(1);
        chk("idle.frame_cnt", fc2, 3);

        // flip accepted while idle lands on the first VBLANK after enable
        FLIP_REQ = 1; step(1); FLIP_REQ = 0;
        ENABLE = 1;
        step(3);
        VBLANK = 1;
        step(1);
        chk("idleflip.disp_addr", da2, 32'h1000_0000);
        chk("idleflip.flip_ack", ack2, 1);
        chk("idleflip.draw_addr", wa2, 32'h1030_0000);
        VBLANK = 0;
        step(3);

        ENABLE = 0; step(2); ENABLE = 1; step(3);
        chk("restart.disp_on", on2, 1);

        FLIP_REQ = 1; step(1);
        VBLANK = 1; step(1);
        FLIP_REQ = 0; VBLANK = 0; step(3);

        FIFO_UNDERFLOW = 1; step(2); FIFO_UNDERFLOW = 0; step(2);
        FIFO_UNDERFLOW = 1; step(2); FIFO_UNDERFLOW = 0; step(2);
        FIFO_UNDERFLOW = 1; step(1); FIFO_OVERFLOW = 1; step(1);
        FIFO_UNDERFLOW = 0; step(2); FIFO_OVERFLOW = 0; step(2);
        chk("err.count3", ec2, 3);

        force u2.err_cnt = 16'hFFFF;
        m_err[0] = 65535;
        step(1);
        release u2.err_cnt;
        step(1);
        chk("sat.forced", ec2, 16'hFFFF);
        FIFO_OVERFLOW = 1; step(2); FIFO_OVERFLOW = 0; step(2);
        FIFO_UNDERFLOW = 1; step(1); FIFO_UNDERFLOW = 0; step(2);
        chk("sat.held", ec2, 16'hFFFF);
        chk("sat.u3_count", ec3, 5);

        FLIP_REQ = 1; step(1); FLIP_REQ = 0;
        chk("pend.flip_ready", rdy2, 0);
        #2 ARESET = 1;
        ENABLE = 0;
        #1;
        chk("arst.disp_on", on2, 0);
        chk("arst.disp_addr", da2, 32'h1000_0000);
        chk("arst.draw_addr", wa2, 32'h1030_0000);
        chk("arst.frame_cnt", fc2, 0);
        chk("arst.err_cnt", ec2, 0);
        chk("arst.flip_ready", rdy2, 1);
        step(2);
        ARESET = 0;
        step(1);
        ENABLE = 1;
        step(3);
        VBLANK = 1;
        step(1);
        chk("postrst.flip_ack", ack2, 0);
        chk("postrst.disp_addr", da2, 32'h1000_0000);
        chk("postrst.frame_cnt", fc2, 1);
        VBLANK = 0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
